// File: rtl/mac_arbiter_pkg.sv
// Shared operand/result types and sizing for the MAC arbiter slice.
package ABC_parameter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 2;

  typedef logic [WIDTH-1:0]   mac_op_t;
  typedef logic [2*WIDTH-1:0] mac_res_t;

endpackage

// File: rtl/mac_arbiter_pipe.sv
// Two-stage multiply-add datapath (res = a*b + c) with valid/id sideband.
// Stage 1 holds the product and zero-extended addend, stage 2 holds the sum.
// Stage-2 data/id only load on a valid stage-1 entry, so they hold otherwise.
module mac_pipe
  import ABC_parameter::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     in_valid_i,
  input  logic     in_id_i,
  input  mac_op_t  a_i,
  input  mac_op_t  b_i,
  input  mac_op_t  c_i,
  output logic     s1_valid_o,
  output logic     s1_id_o,
  output logic     out_valid_o,
  output logic     out_id_o,
  output mac_res_t out_data_o
);

  logic     v1_q, v1_d;
  logic     id1_q, id1_d;
  mac_res_t mul_q, mul_d;
  mac_res_t add_q, add_d;
  logic     v2_q, v2_d;
  logic     id2_q, id2_d;
  mac_res_t data_q, data_d;

  // Next-state for both stages; the full-width product cannot overflow 2*WIDTH bits.
  always_comb begin
    v1_d   = in_valid_i;
    id1_d  = id1_q;
    mul_d  = mul_q;
    add_d  = add_q;
    if (in_valid_i) begin
      id1_d = in_id_i;
      mul_d = mac_res_t'(a_i) * mac_res_t'(b_i);
      add_d = mac_res_t'(c_i);
    end
    v2_d   = v1_q;
    id2_d  = id2_q;
    data_d = data_q;
    if (v1_q) begin
      id2_d  = id1_q;
      data_d = mul_q + add_q;
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q   <= 1'b0;
      id1_q  <= 1'b0;
      mul_q  <= '0;
      add_q  <= '0;
      v2_q   <= 1'b0;
      id2_q  <= 1'b0;
      data_q <= '0;
    end else begin
      v1_q   <= v1_d;
      id1_q  <= id1_d;
      mul_q  <= mul_d;
      add_q  <= add_d;
      v2_q   <= v2_d;
      id2_q  <= id2_d;
      data_q <= data_d;
    end
  end

  assign s1_valid_o  = v1_q;
  assign s1_id_o     = id1_q;
  assign out_valid_o = v2_q;
  assign out_id_o    = id2_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/mac_arbiter.sv
// Round-robin arbiter sharing one mac_pipe between two requesters.
// Handshake: requester i transfers in a cycle where req_valid[i] & req_ready[i];
// req_ready is combinational from req_valid and the rr pointer, at most one bit
// is high, it is low while reset is high, and the result side never stalls.
module mac_arbiter
  import ABC_parameter::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  mac_op_t           a0,
  input  mac_op_t           b0,
  input  mac_op_t           c0,
  input  mac_op_t           a1,
  input  mac_op_t           b1,
  input  mac_op_t           c1,
  output logic              res_valid,
  output logic              res_id,
  output mac_res_t          res_data,
  output logic [CNT_W-1:0]  done_cnt0,
  output logic [CNT_W-1:0]  done_cnt1
);

  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic             grant0, grant1, xfer;
  mac_op_t          sel_a, sel_b, sel_c;
  logic             s1_valid, s1_id;

  // Grant: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant0    = req_valid[0] & (~req_valid[1] | last_q);
    grant1    = req_valid[1] & (~req_valid[0] | ~last_q);
    req_ready = reset ? 2'b00 : {grant1, grant0};
    xfer      = |req_ready;
    last_d    = xfer ? req_ready[1] : last_q;
    sel_a     = req_ready[1] ? a1 : a0;
    sel_b     = req_ready[1] ? b1 : b0;
    sel_c     = req_ready[1] ? c1 : c0;
  end

  mac_pipe u_pipe (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (xfer),
    .in_id_i     (req_ready[1]),
    .a_i         (sel_a),
    .b_i         (sel_b),
    .c_i         (sel_c),
    .s1_valid_o  (s1_valid),
    .s1_id_o     (s1_id),
    .out_valid_o (res_valid),
    .out_id_o    (res_id),
    .out_data_o  (res_data)
  );

  // Counters advance on the same edge that presents a result, so each count
  // already includes the result currently on res_data; they wrap silently.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (s1_valid && !s1_id) cnt0_d = cnt0_q + CNT_W'(1);
    if (s1_valid &&  s1_id) cnt1_d = cnt1_q + CNT_W'(1);
  end

  // Pointer starts at 1 so requester 0 wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      last_q <= last_d;
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign done_cnt0 = cnt0_q;
  assign done_cnt1 = cnt1_q;

endmodule
